// File: rtl/cla_pipelined_adder_if.sv
// Valid/ready operand and result bundle for the pipelined CLA adder/subtractor.
// The producer/consumer side uses master; the adder itself uses slave.
interface cla_pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment per stage,
// two-level lookahead (4-bit blocks + group unit) inside each segment.
module cla_pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  cla_pipelined_adder_if.slave  bus
);
  localparam int NSEG = WIDTH / SEG_W;
  localparam int NB   = SEG_W / 4;

  // Flattened 4-bit lookahead; c[4] with ci=0 doubles as the block's Gstar.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & ci);
    return c;
  endfunction

  // Group unit: each block carry-in is a sum of products, no ripple across blocks.
  function automatic logic [NB:0] group_carries(input logic [NB-1:0] gs, input logic [NB-1:0] ps,
                                                input logic ci);
    logic [NB:0] bc;
    logic        term;
    for (int j = 0; j <= NB; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) term = term & ps[m];
      bc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gs[i];
        for (int m = i + 1; m < j; m++) term = term & ps[m];
        bc[j] = bc[j] | term;
      end
    end
    return bc;
  endfunction

  // Returns {overflow, carry_out, sum} for one segment.
  function automatic logic [SEG_W+1:0] seg_add(input logic [SEG_W-1:0] a, input logic [SEG_W-1:0] b,
                                               input logic ci);
    logic [SEG_W-1:0] g, p, c;
    logic [NB-1:0]    gs, ps;
    logic [NB:0]      bc;
    logic [4:0]       lc;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NB; j++) begin
      lc    = cla4(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gs[j] = lc[4];
      ps[j] = &p[4*j +: 4];
    end
    bc = group_carries(gs, ps, ci);
    lc = '0;
    for (int j = 0; j < NB; j++) begin
      lc           = cla4(g[4*j +: 4], p[4*j +: 4], bc[j]);
      c[4*j +: 4]  = lc[3:0];
    end
    return {lc[3] ^ bc[NB], bc[NB], p ^ c};
  endfunction

  logic             valid_q [NSEG];
  logic             valid_d [NSEG];
  logic [WIDTH-1:0] x_q     [NSEG];
  logic [WIDTH-1:0] x_d     [NSEG];
  logic [WIDTH-1:0] y_q     [NSEG];
  logic [WIDTH-1:0] y_d     [NSEG];
  logic [WIDTH-1:0] s_q     [NSEG];
  logic [WIDTH-1:0] s_d     [NSEG];
  logic             c_q     [NSEG];
  logic             c_d     [NSEG];
  logic             z_q     [NSEG];
  logic             z_d     [NSEG];
  logic             o_q     [NSEG];
  logic             o_d     [NSEG];

  logic advance;

  assign advance      = !valid_q[NSEG-1] || bus.out_ready;
  assign bus.in_ready = advance;

  // NOTE: every temporary and every _d is assigned on each pass before use, so no latch is inferred.
  always_comb begin
    logic [WIDTH-1:0]  src_x, src_y, src_s;
    logic              src_c, src_z, src_v;
    logic [SEG_W+1:0]  res;
    for (int k = 0; k < NSEG; k++) begin
      if (k == 0) begin
        src_x = bus.x;
        src_y = bus.sub ? ~bus.y : bus.y;
        src_s = '0;
        src_c = bus.sub | bus.cin;
        src_z = 1'b1;
        src_v = bus.in_valid;
      end else begin
        src_x = x_q[k-1];
        src_y = y_q[k-1];
        src_s = s_q[k-1];
        src_c = c_q[k-1];
        src_z = z_q[k-1];
        src_v = valid_q[k-1];
      end
      res                     = seg_add(src_x[k*SEG_W +: SEG_W], src_y[k*SEG_W +: SEG_W], src_c);
      valid_d[k]              = src_v;
      x_d[k]                  = src_x;
      y_d[k]                  = src_y;
      s_d[k]                  = src_s;
      s_d[k][k*SEG_W +: SEG_W] = res[SEG_W-1:0];
      c_d[k]                  = res[SEG_W];
      o_d[k]                  = res[SEG_W+1];
      z_d[k]                  = src_z & (res[SEG_W-1:0] == '0);
    end
  end

  // NOTE: the stage registers are plain flops (not a RAM), so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        valid_q[k] <= 1'b0;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
        z_q[k]     <= 1'b0;
        o_q[k]     <= 1'b0;
      end
    end else if (advance) begin
      // NOTE: non-blocking so each stage loads its predecessor's pre-edge value.
      for (int k = 0; k < NSEG; k++) begin
        valid_q[k] <= valid_d[k];
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
        s_q[k]     <= s_d[k];
        c_q[k]     <= c_d[k];
        z_q[k]     <= z_d[k];
        o_q[k]     <= o_d[k];
      end
    end
  end

  assign bus.out_valid = valid_q[NSEG-1];
  assign bus.sum       = s_q[NSEG-1];
  assign bus.cout      = c_q[NSEG-1];
  assign bus.ovf       = o_q[NSEG-1];
  assign bus.zero      = z_q[NSEG-1];
endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Self-checking bench: directed and random vectors against an arithmetic reference
// model, plus parallel parameter-sweep instances.
module tb_cla_pipelined_adder;
  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks;
  int failures;

  cla_pipelined_adder_if #(.WIDTH(W)) bus ();
  cla_pipelined_adder #(.WIDTH(W), .SEG_W(S)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  bit           head_seen;
  bit           check_lat;
  int           n_out;
  bit           sweep_go;

  // Plain arithmetic: unsigned sum/difference for cout, signed W+1-bit result for overflow.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input logic s);
    exp_t             e;
    logic [W:0]       u;
    logic signed [W:0] sd;
    if (s) begin
      u      = {1'b0, a} - {1'b0, b};
      e.cout = (a >= b);
      sd     = $signed({a[W-1], a}) - $signed({b[W-1], b});
    end else begin
      u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.cout = u[W];
      sd     = $signed({a[W-1], a}) + $signed({b[W-1], b}) + $signed({{W{1'b0}}, c});
    end
    e.sum  = u[W-1:0];
    e.ovf  = sd[W] ^ sd[W-1];
    e.zero = (u[W-1:0] == '0);
    e.acc  = 0;
    return e;
  endfunction

  // One cycle: drive, score acceptance/transfer before the edge, observe after it.
  task automatic tick(input logic v, input logic [W-1:0] xx, input logic [W-1:0] yy,
                      input logic c, input logic s, input logic ordy, output bit accepted);
    exp_t         e;
    bit           was_stall;
    logic [W-1:0] prev_sum;
    bus.in_valid  = v;
    bus.x         = xx;
    bus.y         = yy;
    bus.cin       = c;
    bus.sub       = s;
    bus.out_ready = ordy;
    #1;
    checks++;
    if (bus.in_ready !== (!bus.out_valid || ordy)) begin
      failures++;
      $display("FAIL in_ready got=%b exp=%b", bus.in_ready, !bus.out_valid || ordy);
    end
    was_stall = bus.out_valid && !ordy;
    prev_sum  = bus.sum;
    if (bus.out_valid && ordy) begin
      if (sb.size() > 0) void'(sb.pop_front());
      head_seen = 0;
      n_out++;
    end
    accepted = v && bus.in_ready;
    if (accepted) begin
      e     = ref_model(xx, yy, c, s);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    if (was_stall) begin
      checks++;
      if (bus.sum !== prev_sum) begin
        failures++;
        $display("FAIL stall_hold sum got=%h exp=%h", bus.sum, prev_sum);
      end
    end
    if (bus.out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output sum got=%h exp=none", bus.sum);
      end else begin
        e = sb[0];
        if ({bus.sum, bus.cout, bus.ovf, bus.zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
          failures++;
          $display("FAIL result got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                   bus.sum, bus.cout, bus.ovf, bus.zero, e.sum, e.cout, e.ovf, e.zero);
        end
        if (!head_seen && check_lat) begin
          checks++;
          if (cyc - e.acc != N) begin
            failures++;
            $display("FAIL latency got=%0d exp=%0d", cyc - e.acc, N);
          end
        end
        head_seen = 1;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    bit a;
    tick(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), ordy, a);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && (sb.size() > 0 || bus.out_valid); t++) idle(1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b sum=%h c=%b o=%b z=%b exp all 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_carry();
    bit a;
    tick(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, a);
    repeat (3) idle(1'b1);
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_carry got v=%b sum=%h c=%b o=%b z=%b exp v=1 sum=0 c=1 o=0 z=1",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
    end
    drain();
  endtask

  task automatic test_subtract();
    bit a;
    tick(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, a);
    tick(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, a);
    repeat (2) idle(1'b1);
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== {1'b1, 32'hFFFF_FFFE, 3'b000}) begin
      failures++;
      $display("FAIL sub_borrow got v=%b sum=%h c=%b o=%b z=%b exp v=1 sum=fffffffe c=0 o=0 z=0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
    end
    idle(1'b1);
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, 32'h7FFF_FFFF, 2'b11}) begin
      failures++;
      $display("FAIL sub_ovf got v=%b sum=%h c=%b o=%b exp v=1 sum=7fffffff c=1 o=1",
               bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit a;
    int n0 = n_out;
    for (int i = 0; i < 64; i++)
      tick(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, a);
    drain();
    checks++;
    if (n_out - n0 != 64) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=64", n_out - n0);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]   pat = 8'b0110_1001;
    logic [W-1:0] vx[8], vy[8];
    logic         vc[8], vs[8];
    bit           a;
    int           sent = 0;
    int           t = 0;
    int           n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      vx[i] = $urandom;
      vy[i] = $urandom;
      vc[i] = 1'($urandom);
      vs[i] = 1'($urandom);
    end
    check_lat = 0;
    while (sent < 8 && t < 100) begin
      tick(1'b1, vx[sent], vy[sent], vc[sent], vs[sent], pat[t%8], a);
      if (a) sent++;
      t++;
    end
    while ((sb.size() > 0 || bus.out_valid) && t < 200) begin
      idle(pat[t%8]);
      t++;
    end
    checks++;
    if (sent != 8 || sb.size() != 0 || n_out - n0 != 8) begin
      failures++;
      $display("FAIL backpressure sent=%0d pending=%0d delivered=%0d exp 8/0/8", sent, sb.size(), n_out - n0);
    end
    check_lat = 1;
  endtask

  task automatic test_reset_midflight();
    bit a;
    for (int i = 0; i < 3; i++)
      tick(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, a);
    idle(1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0) begin
      failures++;
      $display("FAIL reset_async got v=%b sum=%h exp v=0 sum=0", bus.out_valid, bus.sum);
    end
    sb.delete();
    head_seen = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tick(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, a);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_after_reset cycle=%0d got v=%b exp v=0", i, bus.out_valid);
      end
      idle(1'b1);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 32'd7) begin
      failures++;
      $display("FAIL post_reset got v=%b sum=%h exp v=1 sum=7", bus.out_valid, bus.sum);
    end
    drain();
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 2) ? 64 : 16;
    localparam int SS = (g == 0) ? 4 : (g == 1) ? 16 : 8;
    localparam int NS = SW / SS;

    typedef struct {
      logic [SW-1:0] sum;
      logic          cout;
      logic          ovf;
      int            acc;
    } sexp_t;

    cla_pipelined_adder_if #(.WIDTH(SW)) sbus ();
    cla_pipelined_adder #(.WIDTH(SW), .SEG_W(SS)) u_dut (.clk(clk), .rst_n(rst_n), .bus(sbus));

    sexp_t q[$];
    bit    done_flag = 0;

    function automatic sexp_t ref_add(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                      input logic c, input logic s);
      sexp_t              e;
      logic [SW:0]        u;
      logic signed [SW:0] sd;
      if (s) begin
        u      = {1'b0, a} - {1'b0, b};
        e.cout = (a >= b);
        sd     = $signed({a[SW-1], a}) - $signed({b[SW-1], b});
      end else begin
        u      = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c};
        e.cout = u[SW];
        sd     = $signed({a[SW-1], a}) + $signed({b[SW-1], b}) + $signed({{SW{1'b0}}, c});
      end
      e.sum = u[SW-1:0];
      e.ovf = sd[SW] ^ sd[SW-1];
      e.acc = 0;
      return e;
    endfunction

    function automatic logic [SW-1:0] corner(input int i);
      case (i)
        0:       return '0;
        1:       return {SW{1'b1}};
        default: return {1'b1, {(SW-1){1'b0}}};
      endcase
    endfunction

    initial begin
      logic [SW-1:0] a, b;
      logic [63:0]   r0, r1;
      logic          c, s, v;
      sexp_t         e;
      sbus.in_valid  = 1'b0;
      sbus.x         = '0;
      sbus.y         = '0;
      sbus.cin       = 1'b0;
      sbus.sub       = 1'b0;
      sbus.out_ready = 1'b1;
      wait (sweep_go);
      @(negedge clk);
      for (int i = 0; i < 27 + 500 + NS + 4; i++) begin
        r0 = {$urandom, $urandom};
        r1 = {$urandom, $urandom};
        if (i < 27) begin
          a = corner(i % 3);
          b = corner((i / 3) % 3);
          c = ((i / 9) == 1);
          s = ((i / 9) == 2);
          v = 1'b1;
        end else begin
          a = r0[SW-1:0];
          b = r1[SW-1:0];
          c = 1'($urandom);
          s = 1'($urandom);
          v = (i < 527) && ($urandom_range(7) != 0);
        end
        sbus.in_valid = v;
        sbus.x        = a;
        sbus.y        = b;
        sbus.cin      = c;
        sbus.sub      = s;
        #1;
        if (v && sbus.in_ready) begin
          e     = ref_add(a, b, c, s);
          e.acc = cyc;
          q.push_back(e);
        end
        @(negedge clk);
        if (sbus.out_valid) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL sweep%0d unexpected sum got=%h exp=none", g, sbus.sum);
          end else begin
            e = q.pop_front();
            if ({sbus.sum, sbus.cout, sbus.ovf} !== {e.sum, e.cout, e.ovf}) begin
              failures++;
              $display("FAIL sweep%0d result got sum=%h c=%b o=%b exp sum=%h c=%b o=%b",
                       g, sbus.sum, sbus.cout, sbus.ovf, e.sum, e.cout, e.ovf);
            end
            checks++;
            if (cyc - e.acc != NS) begin
              failures++;
              $display("FAIL sweep%0d latency got=%0d exp=%0d", g, cyc - e.acc, NS);
            end
          end
        end
      end
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL sweep%0d pending got=%0d exp=0", g, q.size());
      end
      done_flag = 1;
    end
  end

  task automatic test_param_sweep();
    sweep_go = 1;
    for (int t = 0; t < 20000 && !(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag); t++)
      @(negedge clk);
    checks++;
    if (!(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag)) begin
      failures++;
      $display("FAIL sweep_timeout got done=%b%b%b exp=111",
               g_sweep[2].done_flag, g_sweep[1].done_flag, g_sweep[0].done_flag);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    n_out     = 0;
    head_seen = 0;
    check_lat = 1;
    sweep_go  = 0;
    test_reset();
    test_add_carry();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cla_pipelined_adder.md
Name: cla_pipelined_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit CLA.
- Operands are split into NSEG = WIDTH/SEG_W segments. Each pipeline stage resolves one segment with a two-level CLA: 4-bit lookahead blocks plus a group lookahead across the blocks. The carry is registered between stages.
- Sits in the datapath between operand registers and the ALU result mux. Uses a valid/ready handshake with full backpressure.

Parameters:
- WIDTH, 32, operand and sum width. Must be a multiple of SEG_W.
- SEG_W, 8, bits resolved per pipeline stage. Must be a multiple of 4. NSEG = WIDTH/SEG_W, range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode valid this cycle
- in_ready  out  1  stage 0 can accept this cycle
- x  in  WIDTH  operand X
- y  in  WIDTH  operand Y
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: X+Y+cin; 1: X-Y, computed as X+~Y+1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for sub, 1 means no borrow
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0

Behaviour:
- Reset (asynchronous on rst_n low):
  - All stage valid bits, out_valid, sum, cout, ovf and zero go to 0.
  - Segment registers go to 0.
  - in_ready is combinational, so it reads 1 while out_valid=0.
- Pipeline: NSEG stages, stage k = 0..NSEG-1.
  - Stage k computes segment k, bits [k*SEG_W +: SEG_W].
  - Inputs to stage k: the registered carry from stage k-1, or the effective cin (sub ? 1 : cin) for k=0.
  - Stage k registers that segment's sum bits.
  - Higher segments of x/y' (y' = sub ? ~y : y) are carried forward unchanged in skew registers.
  - Lower result bits are carried forward alongside.
- Lookahead inside a segment:
  - G = x&y', P = x^y'.
  - 4-bit blocks produce internal carries plus Gstar/Pstar.
  - The group unit produces the block carry-ins and the segment carry-out.
  - No ripple chain longer than 4 bits is permitted.
- Latency: exactly NSEG cycles from an accepted input (in_valid & in_ready at edge t) to out_valid high after edge t+NSEG-1. With the default NSEG=4, out_valid is high in the 4th cycle.
- Throughput: one result per cycle when out_ready is held high.
- Stall rule:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance=0, every stage, including all data, valid and carry registers, holds its value.
  - No bubble compaction.
- Bubbles: a stage with valid=0 may still load data; its contents are don't-care but must not assert out_valid.
- Flags:
  - cout, ovf and zero are registered with the final stage and are valid only while out_valid=1.
  - zero is the AND of per-segment zero bits accumulated through the pipe.
- Transfer and stability:
  - Output transfer occurs on an edge with out_valid & out_ready.
  - sum and flags stay stable while out_valid & !out_ready.
- Input transfer: x/y/cin/sub are sampled only when in_valid & in_ready. Changes while not accepted have no effect.
- Reset mid-operation: all in-flight results are discarded. The first output after reset deassertion comes from the first operand set accepted after it.
- NSEG=1: degenerates to a single registered CLA with 1-cycle latency and the same handshake.

Test Plan:
- Add with carry, WIDTH=32, SEG_W=8, out_ready=1: x=0xFFFF_FFFF, y=0x0000_0001, cin=0, sub=0. Required, 4 cycles after accept: sum=0x0000_0000, cout=1, ovf=0, zero=1. This exercises carry propagation across all segment boundaries.
- Subtract with borrow: x=0x0000_0005, y=0x0000_0007, sub=1, cin=1 (ignored). Required: sum=0xFFFF_FFFE, cout=0, ovf=0, zero=0. Then x=0x8000_0000, y=1, sub=1. Required: sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-to-back streaming: 64 random vectors, one per cycle, out_ready=1. Required: outputs in order, one per cycle after the 4-cycle fill, each equal to the reference model (x ± y + cin) for sum, cout and ovf.
- Backpressure: 8 vectors streamed while out_ready toggles in the pattern 1,0,0,1,0,1,1,0... Required:
  - in_ready=0 exactly when out_valid & !out_ready.
  - sum is unchanged during stalls.
  - No vector is lost or duplicated; the ordered match against the reference model passes.
- Reset mid-flight: 3 vectors accepted, then rst_n pulsed low for 1 cycle, asynchronously, mid-cycle. Required:
  - out_valid=0 and sum=0 immediately on assertion.
  - None of the 3 results ever appears.
  - A new vector x=3, y=4 produces sum=7 after 4 cycles.
- Parameter sweep: (WIDTH,SEG_W) = (16,4), (16,16), (64,8), with 500 random vectors plus the corner values 0, all-ones and 0x80..0 in each mode. Required: a reference match for every vector and latency = WIDTH/SEG_W in every configuration.
